p2s_cp_reg: RTL
===============

Name: p2s_cp_reg

Overview:
- Parallel-to-serial converter with cyclic-prefix insertion on the modulator output side.
- Sits directly downstream of the 8-point complex transform that the serial-to-parallel register feeds.
- Captures one block of 8 complex samples (real/imag, 16 bits each) on a load strobe.
- Streams the last cpLength samples as the prefix, then all 8 samples in order, one complex sample per clock, with valid/done flags.

Parameters:
- portWidth, 16: bit width of each real/imaginary sample.
- registerDepth, 8: samples per block; fixed by the 8 input ports, not to be overridden.
- cpLength, 2: cyclic-prefix length in samples; legal range 0..registerDepth-1.
- counterWidth, 4: width of the internal sample counter; must hold cpLength+registerDepth-1.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- load  input  1  1-cycle strobe; the 16 sample inputs are valid in this cycle.
- in0R..in7R  input  portWidth each  real parts of block samples 0..7.
- in0I..in7I  input  portWidth each  imaginary parts of block samples 0..7.
- serialOutR  output  portWidth  real part of the current output sample.
- serialOutI  output  portWidth  imaginary part of the current output sample.
- valid  output  1  serialOutR/serialOutI carry a sample this cycle.
- busy  output  1  a block is being emitted; high for its cpLength+8 output cycles.
- done  output  1  1-cycle pulse coincident with the last sample of a block.
- overrun  output  1  1-cycle pulse: a load was rejected.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clock edge, including mid-block):
  - state goes to IDLE; counter = 0; buffers zeroed.
  - serialOutR, serialOutI = 0; valid, busy, done, overrun = 0.
  - rst has priority over load in the same cycle; that load is discarded.
- States:
  - IDLE: outputs zero, valid=0.
  - CP: emit bufR/bufI[registerDepth-cpLength+k] for k = 0..cpLength-1.
  - DATA: emit buf[k] for k = 0..7.
- Transitions:
  - IDLE + load -> CP, or DATA directly if cpLength = 0.
  - CP after cpLength samples -> DATA.
  - DATA after sample 7 -> IDLE, or -> CP/DATA if a load is accepted in that cycle.
- Latency: load sampled at edge t; first output sample (valid=1) is registered at edge t and visible in cycle t+1. Samples stay registered, not combinational.
- Block length: exactly cpLength+8 consecutive valid cycles; no gaps within a block.
- done: high with the final DATA sample (buf[7]).
- busy: equals valid.
- Load acceptance:
  - A load is accepted when state is IDLE, or in the final DATA cycle (done=1).
  - A load accepted in the final DATA cycle makes the next block start the following cycle, with valid continuously high (seamless streaming).
  - Inputs are captured into the buffer only on an accepted load.
- Load rejection:
  - A load in any other busy cycle is ignored.
  - The buffer and the block in progress are unaffected.
  - overrun pulses high in the next cycle.
- Outputs are forced to zero whenever valid=0. Data passes through bit-exact; no arithmetic or scaling.
- Counter wraps to 0 at the end of every block; no other wrap condition exists.

Test Plan:
- Single block, cpLength=2, inRk = 16'h0100+k, inIk = 16'h0200+k, load at cycle 5:
  - valid for cycles 6..15.
  - serialOutR sequence: 0106, 0107, 0100..0107; serialOutI likewise with 02xx.
  - done only in cycle 15; outputs 0 in cycle 16.
- Back-to-back: second load (values +16'h0010) asserted in the done cycle:
  - valid stays high for 20 consecutive cycles.
  - Second block starts with 0116.
  - overrun stays 0.
- Overrun: load asserted in the 4th valid cycle:
  - first block completes unchanged.
  - overrun=1 for exactly one cycle.
  - no second block is emitted.
- cpLength=0 build, same data: 8 valid cycles emitting 0100..0107; done on the 8th.
- Reset mid-block: rst high in the 5th valid cycle.
  - Next cycle: all outputs 0, valid=0.
  - A new load after rst deasserts produces a complete, correct 10-sample block.
- Load and rst asserted in the same cycle: no block is emitted; all outputs remain 0.

Source files
------------

// File: rtl/p2s_cp_reg_if.sv
// Bus bundle for the parallel-to-serial / cyclic-prefix register: the
// eight-sample parallel load side and the serial output side.
interface p2s_cp_reg_if #(
    parameter int portWidth = 16
);
    logic                 load;
    logic [portWidth-1:0] in0R, in1R, in2R, in3R, in4R, in5R, in6R, in7R;
    logic [portWidth-1:0] in0I, in1I, in2I, in3I, in4I, in5I, in6I, in7I;
    logic [portWidth-1:0] serialOutR;
    logic [portWidth-1:0] serialOutI;
    logic                 valid;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    // Upstream side: drives the block and the load strobe, watches the stream.
    modport master (
        output load,
        output in0R, in1R, in2R, in3R, in4R, in5R, in6R, in7R,
        output in0I, in1I, in2I, in3I, in4I, in5I, in6I, in7I,
        input  serialOutR, serialOutI, valid, busy, done, overrun
    );

    // Converter side.
    modport slave (
        input  load,
        input  in0R, in1R, in2R, in3R, in4R, in5R, in6R, in7R,
        input  in0I, in1I, in2I, in3I, in4I, in5I, in6I, in7I,
        output serialOutR, serialOutI, valid, busy, done, overrun
    );
endinterface

// File: rtl/p2s_cp_reg.sv
// Parallel-to-serial converter with cyclic-prefix insertion. A block of
// registerDepth complex samples is captured on an accepted load, then the
// last cpLength samples are streamed as a prefix followed by the full block,
// one registered sample per clock. A load landing on the final sample of a
// block is accepted so consecutive blocks stream without a gap.
module p2s_cp_reg #(
    parameter int portWidth     = 16,
    parameter int registerDepth = 8,
    parameter int cpLength      = 2,
    parameter int counterWidth  = 4
) (
    input  logic             clk,
    input  logic             rst,
    p2s_cp_reg_if.slave      bus
);
    localparam int IDX_W     = $clog2(registerDepth);
    localparam int BLOCK_LEN = cpLength + registerDepth;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CP   = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [counterWidth-1:0] cnt, cnt_nxt;          // position within the block, prefix included

    logic [portWidth-1:0]    in_r  [registerDepth];
    logic [portWidth-1:0]    in_i  [registerDepth];
    logic [portWidth-1:0]    buf_r [registerDepth];
    logic [portWidth-1:0]    buf_i [registerDepth];

    logic [portWidth-1:0]    out_r, out_i, out_r_nxt, out_i_nxt;
    logic                    valid_q, valid_nxt;
    logic                    done_q, done_nxt;
    logic                    overrun_q, overrun_nxt;

    logic                    last;                   // final DATA sample is on the output now
    logic                    accept;
    logic                    emit;
    int                      pos;
    int                      idx;
    logic [IDX_W-1:0]        idx_sel;

    // Flatten the individually named sample ports into indexable arrays.
    always_comb begin
        in_r[0] = bus.in0R;  in_i[0] = bus.in0I;
        in_r[1] = bus.in1R;  in_i[1] = bus.in1I;
        in_r[2] = bus.in2R;  in_i[2] = bus.in2I;
        in_r[3] = bus.in3R;  in_i[3] = bus.in3I;
        in_r[4] = bus.in4R;  in_i[4] = bus.in4I;
        in_r[5] = bus.in5R;  in_i[5] = bus.in5I;
        in_r[6] = bus.in6R;  in_i[6] = bus.in6I;
        in_r[7] = bus.in7R;  in_i[7] = bus.in7I;
    end

    // Next-state, next-sample selection and load acceptance.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves one unassigned and a latch is inferred.
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        out_r_nxt   = '0;
        out_i_nxt   = '0;
        valid_nxt   = 1'b0;
        done_nxt    = 1'b0;
        emit        = 1'b0;
        pos         = 0;
        idx         = 0;

        last        = (state == DATA) && (int'(cnt) == BLOCK_LEN - 1);
        accept      = bus.load && ((state == IDLE) || last);
        overrun_nxt = bus.load && !accept;

        if (accept) begin
            emit = 1'b1;
            pos  = 0;
        end else if (state != IDLE && !last) begin
            emit = 1'b1;
            pos  = int'(cnt) + 1;
        end

        if (emit) begin
            cnt_nxt   = counterWidth'(pos);
            valid_nxt = 1'b1;
            done_nxt  = (pos == BLOCK_LEN - 1);
            if (pos < cpLength) begin
                state_nxt = CP;
                idx       = registerDepth - cpLength + pos;
            end else begin
                state_nxt = DATA;
                idx       = pos - cpLength;
            end
        end

        idx_sel = IDX_W'(idx);

        // On the load edge the buffer is not written yet, so the first sample comes from the ports.
        if (emit) begin
            if (accept) begin
                out_r_nxt = in_r[idx_sel];
                out_i_nxt = in_i[idx_sel];
            end else begin
                out_r_nxt = buf_r[idx_sel];
                out_i_nxt = buf_i[idx_sel];
            end
        end
    end

    // State, counter and registered output sample.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_r     <= '0;
            out_i     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            out_r     <= out_r_nxt;
            out_i     <= out_i_nxt;
            valid_q   <= valid_nxt;
            done_q    <= done_nxt;
            overrun_q <= overrun_nxt;
        end
    end

    // Block buffer: captured only on an accepted load.
    always_ff @(posedge clk) begin
        // NOTE: this storage is deliberately cleared on reset so a stale block can never reappear.
        if (rst) begin
            for (int k = 0; k < registerDepth; k++) begin
                buf_r[k] <= '0;
                buf_i[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < registerDepth; k++) begin
                buf_r[k] <= in_r[k];
                buf_i[k] <= in_i[k];
            end
        end
    end

    assign bus.serialOutR = out_r;
    assign bus.serialOutI = out_i;
    assign bus.valid      = valid_q;
    assign bus.busy       = valid_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;

endmodule
